// File: rtl/channel_avg_pkg.sv
// rtl/channel_avg_pkg.sv - shared state encoding and default parameters for channel_averager
package channel_avg_pkg;

    typedef enum logic {
        RUN = 1'b0,
        CLR = 1'b1
    } avg_state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_LOG2_N = 2;
    localparam int DEF_ROUND  = 0;

endpackage

// File: rtl/avg_ch_slice.sv
// rtl/avg_ch_slice.sv - one channel's running sum and sample counter
module avg_ch_slice
    import channel_avg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LOG2_N = DEF_LOG2_N
) (
    input  logic                     clk_2,
    input  logic                     reset_n,
    input  logic                     zero,
    input  logic                     add,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     done,
    output logic [DATA_W+LOG2_N-1:0] sum
);

    localparam int ACC_W = DATA_W + LOG2_N;

    logic [ACC_W-1:0]  accum;
    logic [LOG2_N-1:0] cnt;

    // sum is the total including the sample being presented; done marks the Nth sample
    assign sum  = accum + ACC_W'(data_in);
    assign done = &cnt;

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            accum <= '0;
            cnt   <= '0;
        end else if (zero) begin
            accum <= '0;
            cnt   <= '0;
        end else if (add) begin
            if (done) begin
                accum <= '0;
                cnt   <= '0;
            end else begin
                accum <= sum;
                cnt   <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/channel_averager.sv
// rtl/channel_averager.sv - per-channel N-sample averager with clear sweep and shared output register
module channel_averager
    import channel_avg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int LOG2_N = DEF_LOG2_N,
    parameter int ROUND  = DEF_ROUND,
    localparam int CH_W  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_2,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] data_in,
    output logic              in_ready,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] avg_out,
    output logic              err_ch
);

    localparam int ACC_W = DATA_W + LOG2_N;
    localparam logic [CH_W:0]  NUM_CH_L = (CH_W + 1)'(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic [ACC_W:0] HALF     = (ACC_W + 1)'(1 << (LOG2_N - 1));

    avg_state_t      state, state_nxt;
    logic [CH_W-1:0] clr_idx, clr_idx_nxt;

    logic             in_range, offer, accept, bad;
    logic [NUM_CH-1:0] ch_done;
    logic [ACC_W-1:0] ch_sum [NUM_CH];
    logic             sel_done;
    logic [ACC_W-1:0] sel_sum;
    logic [ACC_W:0]   rnd_sum;
    logic [DATA_W:0]  rnd_q;
    logic [DATA_W-1:0] avg_nxt;

    assign in_range = {1'b0, in_ch} < NUM_CH_L;
    assign offer    = in_valid && in_ready && !clear;
    assign accept   = offer && in_range;
    assign bad      = offer && !in_range;

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RUN;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    // a clear seen in either state (re)starts the sweep at channel 0
    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        in_ready    = 1'b0;
        case (state)
            RUN: begin
                in_ready = 1'b1;
                if (clear) begin
                    state_nxt   = CLR;
                    clr_idx_nxt = '0;
                end
            end
            CLR: begin
                if (clear) begin
                    clr_idx_nxt = '0;
                end else if (clr_idx == LAST_CH) begin
                    state_nxt   = RUN;
                    clr_idx_nxt = '0;
                end else begin
                    clr_idx_nxt = clr_idx + 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slice
        avg_ch_slice #(
            .DATA_W (DATA_W),
            .LOG2_N (LOG2_N)
        ) u_slice (
            .clk_2   (clk_2),
            .reset_n (reset_n),
            .zero    ((state == CLR) && (clr_idx == CH_W'(g))),
            .add     (accept && (in_ch == CH_W'(g))),
            .data_in (data_in),
            .done    (ch_done[g]),
            .sum     (ch_sum[g])
        );
    end

    // only the addressed channel can complete in a given cycle
    always_comb begin
        sel_done = 1'b0;
        sel_sum  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_ch == CH_W'(i)) begin
                sel_done = ch_done[i];
                sel_sum  = ch_sum[i];
            end
        end
    end

    assign rnd_sum = {1'b0, sel_sum} + HALF;
    assign rnd_q   = rnd_sum[ACC_W:LOG2_N];
    assign avg_nxt = (ROUND != 0) ? (rnd_q[DATA_W] ? {DATA_W{1'b1}} : rnd_q[DATA_W-1:0])
                                  : sel_sum[ACC_W-1:LOG2_N];

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            avg_out   <= '0;
            err_ch    <= 1'b0;
        end else begin
            out_valid <= accept && sel_done;
            err_ch    <= bad;
            if (accept && sel_done) begin
                out_ch  <= in_ch;
                avg_out <= avg_nxt;
            end
        end
    end

endmodule

// File: tb/tb_channel_averager.sv
// tb/tb_channel_averager.sv - randomized and directed check of two averager configurations against a sum-of-samples model
module tb_channel_averager;

    logic       clk_2 = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_ch = '0;
    logic [7:0] data_in = '0;

    logic       rdy [2];
    logic       ov  [2];
    logic [1:0] oc  [2];
    logic [7:0] oa  [2];
    logic       oe  [2];

    int n_vec = 0;
    int n_err = 0;

    // instance 0: defaults (4 channels, truncate); instance 1: 3 channels, round half-up
    int nch [2] = '{4, 3};
    int rnd [2] = '{0, 1};

    int macc [2][4];
    int mcnt [2][4];
    int mclr [2];
    int e_val [2], e_ch [2], e_avg [2], e_err [2];

    always #5 clk_2 = ~clk_2;

    channel_averager u_dut0 (
        .clk_2(clk_2), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
        .in_ch(in_ch), .data_in(data_in), .in_ready(rdy[0]), .out_valid(ov[0]),
        .out_ch(oc[0]), .avg_out(oa[0]), .err_ch(oe[0])
    );

    channel_averager #(.NUM_CH(3), .ROUND(1)) u_dut1 (
        .clk_2(clk_2), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
        .in_ch(in_ch), .data_in(data_in), .in_ready(rdy[1]), .out_valid(ov[1]),
        .out_ch(oc[1]), .avg_out(oa[1]), .err_ch(oe[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_zero(input int k);
        for (int c = 0; c < 4; c++) begin
            macc[k][c] = 0;
            mcnt[k][c] = 0;
        end
    endtask

    // one clock: drive, predict, clock, compare
    task automatic cyc(input bit v, input int ch, input int d, input bit c);
        int a;
        in_valid = v;
        in_ch    = 2'(ch);
        data_in  = 8'(d);
        clear    = c;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("ready%0d", k), rdy[k], (mclr[k] == 0));
            e_val[k] = 0;
            e_err[k] = 0;
            if (mclr[k] == 0) begin
                if (c) begin
                    mclr[k] = nch[k];
                    model_zero(k);
                end else if (v && ch >= nch[k]) begin
                    e_err[k] = 1;
                end else if (v) begin
                    macc[k][ch] += d;
                    mcnt[k][ch] += 1;
                    if (mcnt[k][ch] == 4) begin
                        a = rnd[k] ? (macc[k][ch] + 2) / 4 : macc[k][ch] / 4;
                        e_val[k] = 1;
                        e_ch[k]  = ch;
                        e_avg[k] = (a > 255) ? 255 : a;
                        macc[k][ch] = 0;
                        mcnt[k][ch] = 0;
                    end
                end
            end else begin
                mclr[k] = c ? nch[k] : mclr[k] - 1;
            end
        end
        @(posedge clk_2);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("out_valid%0d", k), ov[k], e_val[k]);
            check($sformatf("err_ch%0d", k), oe[k], e_err[k]);
            check($sformatf("out_ch%0d", k), oc[k], e_ch[k]);
            check($sformatf("avg_out%0d", k), oa[k], e_avg[k]);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        clear    = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            model_zero(k);
            mclr[k] = 0;
            e_val[k] = 0; e_ch[k] = 0; e_avg[k] = 0; e_err[k] = 0;
            check($sformatf("rst_valid%0d", k), ov[k], 0);
            check($sformatf("rst_err%0d", k), oe[k], 0);
            check($sformatf("rst_ch%0d", k), oc[k], 0);
            check($sformatf("rst_avg%0d", k), oa[k], 0);
        end
        @(negedge clk_2);
        reset_n = 1'b1;
        @(posedge clk_2);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rel_valid%0d", k), ov[k], 0);
            check($sformatf("rel_ready%0d", k), rdy[k], 1);
        end
    endtask

    initial begin
        int busy;
        int s3 [4] = '{8, 8, 8, 8};

        @(posedge clk_2);
        #1;
        do_reset();

        // ch0 10,20,30,40 -> 25
        cyc(1, 0, 10, 0); cyc(1, 0, 20, 0); cyc(1, 0, 30, 0); cyc(1, 0, 40, 0);
        check("avg_25", oa[0], 25);
        check("valid_25", ov[0], 1);

        // ch2 saturating input, both rounding modes
        for (int i = 0; i < 4; i++) cyc(1, 2, 255, 0);
        check("avg_255_trunc", oa[0], 255);
        check("avg_255_round", oa[1], 255);

        // interleave ch1 {4,4,5,5} with ch3 {100 x4}
        cyc(1, 1, 4, 0); cyc(1, 3, 100, 0); cyc(1, 1, 4, 0); cyc(1, 3, 100, 0);
        cyc(1, 1, 5, 0); cyc(1, 3, 100, 0); cyc(1, 1, 5, 0);
        check("ch1_trunc", oa[0], 4);
        check("ch1_round", oa[1], 5);
        cyc(1, 3, 100, 0);
        check("ch3_avg", oa[0], 100);
        check("ch3_ch", oc[0], 3);

        // partial ch3 then clear: exactly NUM_CH not-ready cycles
        cyc(1, 3, 50, 0); cyc(1, 3, 50, 0);
        cyc(1, 3, 50, 1);
        busy = 0;
        for (int i = 0; i < 6; i++) begin
            if (!rdy[0]) busy++;
            cyc(0, 0, 0, 0);
        end
        check("clr_cycles", busy, 4);
        for (int i = 0; i < 4; i++) cyc(1, 3, s3[i], 0);
        check("ch3_after_clr", oa[0], 8);

        // out-of-range channel on the 3-channel instance
        cyc(1, 3, 99, 0);
        check("err_pulse", oe[1], 1);
        cyc(0, 0, 0, 0);
        check("err_once", oe[1], 0);

        // partial sums discarded by reset
        cyc(1, 0, 200, 0); cyc(1, 0, 200, 0); cyc(1, 0, 200, 0);
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0);
        check("post_rst_avg", oa[0], 1);

        // clear restarted mid-sweep
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 0); cyc(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r == 0) do_reset();
            else cyc($urandom_range(0, 9) < 7, $urandom_range(0, 3),
                     ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255),
                     $urandom_range(0, 59) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/channel_averager.md
CHANNEL_AVERAGER -- requirements
Module: channel_averager

Interface
REQ-001 Parameter DATA_W, default 8: sample and average width in bits.
REQ-002 Parameter NUM_CH, default 4: number of independent channels, range 2..16.
REQ-003 Parameter LOG2_N, default 2: samples per average is N = 2^LOG2_N, range 1..6.
REQ-004 Parameter ROUND, default 0: 0 truncates, 1 rounds half-up.
REQ-005 clk_2  in  1  clock; all state SHALL update on the rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 clear  in  1  synchronous request to zero all channel accumulators and counters.
REQ-008 in_valid  in  1  sample present on data_in/in_ch.
REQ-009 in_ch  in  CH_W = max(1, $clog2(NUM_CH))  channel index of the sample.
REQ-010 data_in  in  DATA_W  unsigned temperature sample.
REQ-011 in_ready  out  1  block can accept a sample this cycle.
REQ-012 out_valid  out  1  single-cycle pulse: avg_out/out_ch are valid.
REQ-013 out_ch  out  CH_W  channel of the completed average.
REQ-014 avg_out  out  DATA_W  averaged reading.
REQ-015 err_ch  out  1  single-cycle pulse: sample with in_ch >= NUM_CH was dropped.

Function
REQ-016 The FSM SHALL have states RUN and CLR; in_ready SHALL be 1 in RUN and 0 in CLR.
REQ-017 A sample SHALL be accepted when in_valid && in_ready && !clear && in_ch < NUM_CH.
REQ-018 Each channel SHALL hold an accumulator of DATA_W+LOG2_N bits, so it never overflows, and a LOG2_N-bit sample counter.
REQ-019 Accepted non-final sample: accum[c] += data_in and cnt[c] += 1.
REQ-020 Accepted Nth sample (cnt[c] == N-1): sum = accum[c] + data_in; accum[c] and cnt[c] SHALL return to 0 that edge.
REQ-021 On the Nth sample's edge, out_valid=1, out_ch=c and avg_out=sum>>LOG2_N (ROUND=0) or (sum + 2^(LOG2_N-1))>>LOG2_N saturated to 2^DATA_W-1 (ROUND=1); latency is 1 cycle from acceptance.
REQ-022 avg_out and out_ch SHALL hold their last value while out_valid=0.
REQ-023 Channels SHALL be independent; interleaved samples SHALL not affect other channels.
REQ-024 in_valid with in_ch >= NUM_CH while in_ready=1: no state change; err_ch SHALL pulse the next cycle.
REQ-025 clear in RUN -> CLR; any coincident sample SHALL be discarded.
REQ-026 CLR SHALL zero one channel per cycle, channel 0 first, and return to RUN after exactly NUM_CH cycles.
REQ-027 clear asserted during CLR SHALL restart the sweep at channel 0.
REQ-028 No out_valid or err_ch SHALL be generated in CLR.

Reset
REQ-029 reset_n low SHALL asynchronously force state RUN and zero all accumulators and counters.
REQ-030 During reset: out_valid=0, err_ch=0, avg_out=0, out_ch=0; in_ready=1 from the first edge after release.
REQ-031 Reset mid-accumulation or mid-sweep SHALL discard all partial sums; no pulse SHALL be produced on release.

Structure
REQ-032 Package channel_avg_pkg SHALL hold the state enum (RUN, CLR) and the default parameter constants.
REQ-033 One sub-module, avg_ch_slice, SHALL implement one channel's accumulator/counter; the top SHALL instantiate NUM_CH copies via generate and arbitrate the output register.

Verification
REQ-034 Defaults, after reset: ch0 samples 10,20,30,40 -> one cycle after 40: out_valid=1, out_ch=0, avg_out=25.
REQ-035 ch2 four samples of 255 -> avg_out=255; no wrap in ROUND=0 or ROUND=1.
REQ-036 Interleave ch1 {4,4,5,5} with ch3 {100,100,100,100} -> ch1 avg_out=4 (ROUND=0) or 5 (ROUND=1); ch3 avg_out=100; ordering follows completion.
REQ-037 ch3 two samples of 50, then clear -> in_ready=0 for exactly 4 cycles; then ch3 samples 8,8,8,8 -> avg_out=8.
REQ-038 NUM_CH=3: in_ch=3, data_in=99 -> err_ch pulses once; ch0-2 counts unchanged.
REQ-039 ch0 three samples, reset_n pulsed low, then ch0 samples 1,1,1,1 -> first out_valid carries avg_out=1.
